os_mac_pe_drain: RTL and testbench
==================================

// Module: os_mac_pe_drain
// PURPOSE
// Next-generation output-stationary GEMM processing element for the systolic array.
// Computes a NumInputs-wide signed dot product per beat, with an optional pipelined multiply.
// Accumulates exactly k_len_i valid beats, with optional saturation.
// Drains results along a valid/ready chain that replaces the old mux-select flush.
// Forwards A east and B south one cycle later, with their valids.
// PARAMETERS
// InDataWidth  8   operand element width (signed)
// NumInputs    4   operand pairs per beat
// OutDataWidth 32  accumulator/result width; must be >= 2*InDataWidth+$clog2(NumInputs)
// MultPipe     1   product pipeline stages, 0 or 1
// Saturate     1   1: clamp accumulator at signed min/max; 0: two's-complement wrap
// KWidth       16  width of the beat counter / k_len_i
// PORTS
// clk_i          in   1                        clock
// rst_ni         in   1                        asynchronous, active-low reset
// a_i / b_i      in   NumInputs*InDataWidth    operand vectors (signed)
// a_valid_i / b_valid_i  in  1                 operand valids
// a_o / b_o      out  NumInputs*InDataWidth    registered operands to east / south PE
// a_valid_o / b_valid_o  out 1                 registered valids to east / south PE
// start_i        in   1                        begin tile (honoured only in IDLE)
// k_len_i        in   KWidth                   beats to accumulate; sampled on start_i
// upstream_en_i  in   1                        0: PE is chain head, no upstream results
// acc_in_i       in   OutDataWidth             upstream result (drain chain)
// acc_in_valid_i / acc_in_last_i  in  1        upstream valid / last-of-chain
// acc_in_ready_o out  1                        upstream accepted
// acc_o          out  OutDataWidth             result toward array edge
// acc_valid_o / acc_last_o  out  1             result valid / last-of-chain
// acc_ready_i    in   1                        downstream accepts
// busy_o         out  1                        state != IDLE
// sat_o          out  1                        sticky overflow flag for current tile
// BEHAVIOUR
// - Reset: all outputs 0, accumulator 0, counter 0, pipeline valids 0, state IDLE.
//   Reset mid-operation abandons the tile; no partial result is emitted.
// - Forwarding:
//   - a_o/b_o are registered each cycle: data when its valid is high, else 0.
//   - a_valid_o/b_valid_o are registered copies of the input valids.
//   - Forwarding runs in every state.
// - Product:
//   - Dot product of the registered a/b, each pair multiplied as signed, summed at full width.
//   - Sign-extended to OutDataWidth.
//   - prod_valid = a_valid_o & b_valid_o, delayed MultPipe cycles alongside the data.
// - Accumulate: acc_next = acc + prod.
//   - Saturate=1: on signed overflow, clamp to max/min and set sat_o.
//   - Saturate=0: wrap; sat_o still flags the overflow.
// - FSM IDLE/ACC/HOLD/DRAIN:
//   - IDLE: on start_i, clear acc, sat_o and counter, latch k_len_i.
//     Go to HOLD if k_len_i==0, else ACC.
//   - ACC: each prod_valid adds into acc and increments the counter.
//     The cycle the counter reaches k_len, go to HOLD. Later prod_valid is discarded.
//   - HOLD: acc_valid_o=1, acc_o=acc, acc_last_o=!upstream_en_i.
//     acc_o must stay stable while acc_ready_i=0.
//     On acc_ready_i, go to DRAIN if upstream_en_i, else IDLE.
//   - DRAIN: combinational pass-through.
//     acc_o=acc_in_i, acc_valid_o=acc_in_valid_i, acc_last_o=acc_in_last_i, acc_in_ready_o=acc_ready_i.
//     When a beat with acc_in_last_i is accepted, go to IDLE.
//     acc_in_ready_o=0 in all other states.
// - start_i outside IDLE is ignored. prod_valid outside ACC is discarded.
//   Valid gaps are legal; only valid beats count.
// - Latency: result appears in HOLD 1 cycle after the last counted beat.
//   Input to accumulator is 1+MultPipe cycles.
// TESTING
// - Basic dot product: start, k_len=3, a={1,2,3,4}, b={1,1,1,1} x3 beats,
//   upstream_en_i=0 -> acc_o=30, acc_valid_o=1, acc_last_o=1.
// - Saturation: OutDataWidth=20, a=b=-128 all lanes, k_len=8 -> acc_o=524287, sat_o=1.
//   Same case with Saturate=0 -> wrapped value, sat_o=1.
// - Backpressure and chain: own result 5, acc_ready_i low 3 cycles -> acc_o held at 5.
//   Then upstream 7 with last=1 -> acc_o=7, acc_last_o=1, then IDLE.
// - Boundaries: k_len=0 -> HOLD next cycle with acc_o=0.
//   start_i during ACC is ignored; valid gaps (1,0,0,1,1) with k_len=3 -> correct sum.
// - Forwarding: a_i=0x05 with valid -> a_o=0x05 next cycle; valid low -> a_o=0.
//   Holds for MultPipe=0 and 1.
// - Reset mid-ACC: assert rst_ni low -> IDLE, acc=0, busy_o=0; next tile computes correctly.

Source files
------------

// File: rtl/os_mac_pe_drain.sv
// -----------------------------------------------------------------------------
// os_mac_pe_drain
// Output-stationary GEMM processing element with a valid/ready drain chain.
//
// Each beat computes a NumInputs-wide signed dot product of the registered
// A/B operand vectors. The optional product pipeline stage (MultPipe) delays
// the product and its valid. The PE accumulates exactly k_len_i valid beats,
// with saturation or wrap on overflow, and then presents its own result.
// After that result is taken, the PE passes upstream results through until
// the last-of-chain beat has been accepted.
//
// Handshake rule (both the acc_o/acc_ready_i link and the acc_in link):
// a beat transfers on a rising clk_i edge where valid and ready are both
// high. While valid is high and ready is low, the producer keeps data, valid
// and last unchanged.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   a_i/b_i, a_valid_i/b_valid_i  operand vectors (signed lanes) and valids
//   a_o/b_o, a_valid_o/b_valid_o  operands and valids forwarded east/south, one cycle later
//   start_i, k_len_i              begin a tile (IDLE only); beats to accumulate
//   upstream_en_i                 0: this PE heads the chain (no upstream results)
//   acc_in_i, acc_in_valid_i,
//   acc_in_last_i, acc_in_ready_o upstream drain input
//   acc_o, acc_valid_o,
//   acc_last_o, acc_ready_i       result/drain output toward the array edge
//   busy_o                        state is not IDLE
//   sat_o                         sticky overflow flag for the current tile
//   state_o                       FSM state (debug visibility)
//
// OutDataWidth must be at least 2*InDataWidth + $clog2(NumInputs).
// -----------------------------------------------------------------------------
module os_mac_pe_drain #(
   parameter int InDataWidth  = 8,
   parameter int NumInputs    = 4,
   parameter int OutDataWidth = 32,
   parameter int MultPipe     = 1,
   parameter int Saturate     = 1,
   parameter int KWidth       = 16
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NumInputs*InDataWidth-1:0] a_i,
   input  logic                             a_valid_i,
   input  logic [NumInputs*InDataWidth-1:0] b_i,
   input  logic                             b_valid_i,
   output logic [NumInputs*InDataWidth-1:0] a_o,
   output logic                             a_valid_o,
   output logic [NumInputs*InDataWidth-1:0] b_o,
   output logic                             b_valid_o,
   input  logic                             start_i,
   input  logic [KWidth-1:0]                k_len_i,
   input  logic                             upstream_en_i,
   input  logic [OutDataWidth-1:0]          acc_in_i,
   input  logic                             acc_in_valid_i,
   input  logic                             acc_in_last_i,
   output logic                             acc_in_ready_o,
   output logic [OutDataWidth-1:0]          acc_o,
   output logic                             acc_valid_o,
   output logic                             acc_last_o,
   input  logic                             acc_ready_i,
   output logic                             busy_o,
   output logic                             sat_o,
   output logic [1:0]                       state_o
);

   localparam int PairWidth = 2 * InDataWidth;
   localparam int ProdWidth = PairWidth + $clog2(NumInputs);

   localparam logic [OutDataWidth-1:0] MaxVal = {1'b0, {(OutDataWidth-1){1'b1}}};
   localparam logic [OutDataWidth-1:0] MinVal = {1'b1, {(OutDataWidth-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t state_q, state_d;

   // ---------------------------------------------------------------------------
   // Operand forwarding: runs in every state. Invalid data is zeroed so the
   // neighbour never sees stale operands.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_o       <= '0;
         b_o       <= '0;
         a_valid_o <= 1'b0;
         b_valid_o <= 1'b0;
      end else begin
         a_o       <= a_valid_i ? a_i : '0;
         b_o       <= b_valid_i ? b_i : '0;
         a_valid_o <= a_valid_i;
         b_valid_o <= b_valid_i;
      end
   end

   // ---------------------------------------------------------------------------
   // Dot product of the registered operands. Each lane is sign-extended to the
   // pair width before multiplying so the product is exact.
   // ---------------------------------------------------------------------------
   logic signed [ProdWidth-1:0] lane_prod [NumInputs];

   for (genvar g = 0; g < NumInputs; g++) begin : g_lane
      logic signed [PairWidth-1:0] a_ext;
      logic signed [PairWidth-1:0] b_ext;
      logic signed [PairWidth-1:0] pair;

      assign a_ext        = PairWidth'($signed(a_o[g*InDataWidth +: InDataWidth]));
      assign b_ext        = PairWidth'($signed(b_o[g*InDataWidth +: InDataWidth]));
      assign pair         = a_ext * b_ext;
      assign lane_prod[g] = ProdWidth'(pair);
   end

   logic signed [ProdWidth-1:0] dot;

   always_comb begin
      dot = '0;
      for (int i = 0; i < NumInputs; i++) begin
         dot = dot + lane_prod[i];
      end
   end

   logic signed [OutDataWidth-1:0] prod_comb;
   logic                           prod_valid_comb;

   assign prod_comb       = OutDataWidth'(dot);
   assign prod_valid_comb = a_valid_o & b_valid_o;

   logic [OutDataWidth-1:0] prod;
   logic                    prod_valid;

   if (MultPipe != 0) begin : g_mult_pipe
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            prod       <= '0;
            prod_valid <= 1'b0;
         end else begin
            prod       <= prod_comb;
            prod_valid <= prod_valid_comb;
         end
      end
   end else begin : g_mult_comb
      assign prod       = prod_comb;
      assign prod_valid = prod_valid_comb;
   end

   // ---------------------------------------------------------------------------
   // Accumulator datapath. One guard bit exposes signed overflow: the two top
   // bits of the widened sum differ exactly when the true sum is out of range.
   // ---------------------------------------------------------------------------
   logic [OutDataWidth-1:0] acc_q;
   logic [KWidth-1:0]       cnt_q;
   logic [KWidth-1:0]       k_q;
   logic                    sat_q;

   logic [OutDataWidth:0]   sum_wide;
   logic                    ovf;
   logic [OutDataWidth-1:0] acc_next;

   assign sum_wide = {acc_q[OutDataWidth-1], acc_q} + {prod[OutDataWidth-1], prod};
   assign ovf      = sum_wide[OutDataWidth] ^ sum_wide[OutDataWidth-1];

   always_comb begin
      acc_next = sum_wide[OutDataWidth-1:0];
      if (ovf && (Saturate != 0)) begin
         // guard bit holds the true sign: negative overflow clamps to min
         acc_next = sum_wide[OutDataWidth] ? MinVal : MaxVal;
      end
   end

   // Control strobes from the FSM
   logic tile_clear;
   logic acc_en;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
         cnt_q <= '0;
         k_q   <= '0;
         sat_q <= 1'b0;
      end else if (tile_clear) begin
         acc_q <= '0;
         cnt_q <= '0;
         k_q   <= k_len_i;
         sat_q <= 1'b0;
      end else if (acc_en) begin
         acc_q <= acc_next;
         cnt_q <= cnt_q + KWidth'(1);
         if (ovf) begin
            sat_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      tile_clear     = 1'b0;
      acc_en         = 1'b0;
      acc_o          = '0;
      acc_valid_o    = 1'b0;
      acc_last_o     = 1'b0;
      acc_in_ready_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               tile_clear = 1'b1;
               state_d    = (k_len_i == '0) ? HOLD : ACC;
            end
         end

         ACC: begin
            if (prod_valid) begin
               acc_en = 1'b1;
               // this beat is the last one counted; later beats are dropped
               if (cnt_q + KWidth'(1) == k_q) begin
                  state_d = HOLD;
               end
            end
         end

         HOLD: begin
            acc_o       = acc_q;
            acc_valid_o = 1'b1;
            acc_last_o  = !upstream_en_i;
            if (acc_ready_i) begin
               state_d = upstream_en_i ? DRAIN : IDLE;
            end
         end

         DRAIN: begin
            acc_o          = acc_in_i;
            acc_valid_o    = acc_in_valid_i;
            acc_last_o     = acc_in_last_i;
            acc_in_ready_o = acc_ready_i;
            if (acc_in_valid_i && acc_ready_i && acc_in_last_i) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_o  = (state_q != IDLE);
   assign sat_o   = sat_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_os_mac_pe_drain.sv
// -----------------------------------------------------------------------------
// tb_os_mac_pe_drain
// Three PEs share one stimulus stream:
//   dut0 : defaults (32-bit, saturating, pipelined multiply)
//   duts : 20-bit, saturating, combinational multiply
//   dutw : 20-bit, wrapping, pipelined multiply
// A reference model accumulates each driven beat for all three widths/modes,
// and the expected {sat, acc} values are queued when the tile's stimulus is
// complete. They are popped and compared when the PEs present their results.
// -----------------------------------------------------------------------------
module tb_os_mac_pe_drain;

   localparam longint Max32 = 2147483647;
   localparam longint Min32 = -Max32 - 1;
   localparam longint Max20 = 524287;
   localparam longint Min20 = -Max20 - 1;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus
   logic [31:0] a_in, b_in;
   logic        a_v, b_v;
   logic        start;
   logic [15:0] k_len;
   logic        upstream_en;
   logic [31:0] acc_in;
   logic [19:0] acc_in20;
   logic        acc_in_valid, acc_in_last;
   logic        acc_ready;

   assign acc_in20 = acc_in[19:0];

   // per-DUT outputs
   logic [31:0] a_o0, b_o0, a_os, b_os, a_ow, b_ow;
   logic        av0, bv0, avs, bvs, avw, bvw;
   logic        inr0, inrs, inrw;
   logic [31:0] acc0;
   logic [19:0] accs, accw;
   logic        accv0, accvs, accvw;
   logic        accl0, accls, acclw;
   logic        busy0, busys, busyw;
   logic        sat0, sats, satw;
   logic [1:0]  st0, sts, stw;

   os_mac_pe_drain dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .a_i(a_in), .a_valid_i(a_v), .b_i(b_in), .b_valid_i(b_v),
      .a_o(a_o0), .a_valid_o(av0), .b_o(b_o0), .b_valid_o(bv0),
      .start_i(start), .k_len_i(k_len), .upstream_en_i(upstream_en),
      .acc_in_i(acc_in), .acc_in_valid_i(acc_in_valid), .acc_in_last_i(acc_in_last),
      .acc_in_ready_o(inr0), .acc_o(acc0), .acc_valid_o(accv0), .acc_last_o(accl0),
      .acc_ready_i(acc_ready), .busy_o(busy0), .sat_o(sat0), .state_o(st0)
   );

   os_mac_pe_drain #(.OutDataWidth(20), .MultPipe(0), .Saturate(1)) duts (
      .clk_i(clk), .rst_ni(rst_n),
      .a_i(a_in), .a_valid_i(a_v), .b_i(b_in), .b_valid_i(b_v),
      .a_o(a_os), .a_valid_o(avs), .b_o(b_os), .b_valid_o(bvs),
      .start_i(start), .k_len_i(k_len), .upstream_en_i(upstream_en),
      .acc_in_i(acc_in20), .acc_in_valid_i(acc_in_valid), .acc_in_last_i(acc_in_last),
      .acc_in_ready_o(inrs), .acc_o(accs), .acc_valid_o(accvs), .acc_last_o(accls),
      .acc_ready_i(acc_ready), .busy_o(busys), .sat_o(sats), .state_o(sts)
   );

   os_mac_pe_drain #(.OutDataWidth(20), .MultPipe(1), .Saturate(0)) dutw (
      .clk_i(clk), .rst_ni(rst_n),
      .a_i(a_in), .a_valid_i(a_v), .b_i(b_in), .b_valid_i(b_v),
      .a_o(a_ow), .a_valid_o(avw), .b_o(b_ow), .b_valid_o(bvw),
      .start_i(start), .k_len_i(k_len), .upstream_en_i(upstream_en),
      .acc_in_i(acc_in20), .acc_in_valid_i(acc_in_valid), .acc_in_last_i(acc_in_last),
      .acc_in_ready_o(inrw), .acc_o(accw), .acc_valid_o(accvw), .acc_last_o(acclw),
      .acc_ready_i(acc_ready), .busy_o(busyw), .sat_o(satw), .state_o(stw)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard and reference model
   // ---------------------------------------------------------------------------
   int n_checks;
   int n_pass;

   logic [32:0] exp_q[$];
   logic [20:0] exp_s_q[$];
   logic [20:0] exp_w_q[$];

   longint m_acc32, m_acc20s, m_acc20w;
   logic   m_f32, m_f20s, m_f20w;
   int     m_cnt, m_k;

   function automatic longint dot4(input logic [31:0] a, input logic [31:0] b);
      longint s;
      logic signed [7:0] x, y;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         x = a[8*i +: 8];
         y = b[8*i +: 8];
         s = s + longint'(x) * longint'(y);
      end
      return s;
   endfunction

   task automatic model_beat(input logic [31:0] a, input logic [31:0] b);
      longint p, s;
      if (m_cnt < m_k) begin
         p = dot4(a, b);
         m_cnt++;
         s = m_acc32 + p;
         if (s > Max32) begin m_acc32 = Max32; m_f32 = 1'b1; end
         else if (s < Min32) begin m_acc32 = Min32; m_f32 = 1'b1; end
         else m_acc32 = s;
         s = m_acc20s + p;
         if (s > Max20) begin m_acc20s = Max20; m_f20s = 1'b1; end
         else if (s < Min20) begin m_acc20s = Min20; m_f20s = 1'b1; end
         else m_acc20s = s;
         s = m_acc20w + p;
         if (s > Max20) begin s = s - 1048576; m_f20w = 1'b1; end
         else if (s < Min20) begin s = s + 1048576; m_f20w = 1'b1; end
         m_acc20w = s;
      end
   endtask

   task automatic push_expect();
      logic [63:0] v32, v20s, v20w;
      v32  = m_acc32;
      v20s = m_acc20s;
      v20w = m_acc20w;
      exp_q.push_back({m_f32, v32[31:0]});
      exp_s_q.push_back({m_f20s, v20s[19:0]});
      exp_w_q.push_back({m_f20w, v20w[19:0]});
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks (all drive right after a falling edge)
   // ---------------------------------------------------------------------------
   task automatic start_tile(input int k);
      start   = 1'b1;
      k_len   = 16'(k);
      m_k     = k;
      m_cnt   = 0;
      m_acc32 = 0; m_acc20s = 0; m_acc20w = 0;
      m_f32   = 1'b0; m_f20s = 1'b0; m_f20w = 1'b0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
      a_in = a;
      b_in = b;
      a_v  = 1'b1;
      b_v  = 1'b1;
      model_beat(a, b);
      @(negedge clk);
      a_v  = 1'b0;
      b_v  = 1'b0;
      a_in = 32'h0;
      b_in = 32'h0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for all three PEs to present a result, then compares it against
   // the head of the scoreboard. Optionally releases the result afterwards.
   task automatic collect(input string name, input bit release_hold);
      int waited;
      logic [32:0] e0;
      logic [20:0] es, ew;
      waited = 0;
      while (!(accv0 && accvs && accvw) && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      e0 = exp_q.pop_front();
      es = exp_s_q.pop_front();
      ew = exp_w_q.pop_front();
      n_checks++;
      if (!(accv0 && accvs && accvw))
         $display("FAIL %s_hold_wait: valids=%b%b%b required 111", name, accv0, accvs, accvw);
      else n_pass++;
      n_checks++;
      if ({sat0, acc0} !== e0) $display("FAIL %s_acc32: got sat=%b acc=%0d required sat=%b acc=%0d", name, sat0, $signed(acc0), e0[32], $signed(e0[31:0]));
      else n_pass++;
      n_checks++;
      if ({sats, accs} !== es) $display("FAIL %s_acc20_sat: got sat=%b acc=%0d required sat=%b acc=%0d", name, sats, $signed(accs), es[20], $signed(es[19:0]));
      else n_pass++;
      n_checks++;
      if ({satw, accw} !== ew) $display("FAIL %s_acc20_wrap: got sat=%b acc=%0d required sat=%b acc=%0d", name, satw, $signed(accw), ew[20], $signed(ew[19:0]));
      else n_pass++;
      n_checks++;
      if ({accl0, accls, acclw} !== {3{!upstream_en}}) $display("FAIL %s_last: got %b%b%b required %b", name, accl0, accls, acclw, {3{!upstream_en}});
      else n_pass++;
      if (release_hold) begin
         acc_ready = 1'b1;
         @(negedge clk);
         acc_ready = 1'b0;
         n_checks++;
         if ({busy0, busys, busyw} !== 3'b000) $display("FAIL %s_release_idle: busy=%b%b%b required 000", name, busy0, busys, busyw);
         else n_pass++;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Test tasks
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst_n = 1'b0;
      idle_cycles(2);
      n_checks++;
      if ({accv0, accvs, accvw, busy0, busys, busyw, sat0, sats, satw} !== 9'b0) $display("FAIL reset_ctrl: got %b required 0", {accv0, accvs, accvw, busy0, busys, busyw, sat0, sats, satw});
      else n_pass++;
      n_checks++;
      if ({acc0, accs, accw, a_o0, b_o0, av0, bv0, inr0} !== '0) $display("FAIL reset_data: acc0=%h a_o0=%h b_o0=%h required 0", acc0, a_o0, b_o0);
      else n_pass++;
      rst_n = 1'b1;
      idle_cycles(1);
   endtask

   task automatic test_basic();
      upstream_en = 1'b0;
      start_tile(3);
      repeat (3) send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
      push_expect();
      collect("basic", 1'b1);
   endtask

   task automatic test_saturation();
      upstream_en = 1'b0;
      start_tile(8);
      repeat (8) send_beat(32'h80808080, 32'h80808080);
      push_expect();
      collect("saturation", 1'b1);
   endtask

   task automatic test_gaps();
      upstream_en = 1'b0;
      start_tile(3);
      send_beat(32'h05FB0A02, 32'h07030CFE);
      idle_cycles(2);
      send_beat(32'h7F7F8080, 32'h01FF7F80);
      send_beat(32'hF0102030, 32'h11223344);
      push_expect();
      collect("gaps", 1'b1);
   endtask

   task automatic test_start_ignored();
      upstream_en = 1'b0;
      start_tile(4);
      send_beat(32'h01020304, 32'h05060708);
      send_beat(32'hFFFEFDFC, 32'h02020202);
      start = 1'b1;
      k_len = 16'd1;
      @(negedge clk);
      start = 1'b0;
      k_len = 16'd4;
      send_beat(32'h10203040, 32'hFF01FF01);
      send_beat(32'h0A0B0C0D, 32'h0D0C0B0A);
      push_expect();
      collect("start_ignored", 1'b1);
   endtask

   task automatic test_extra_beats();
      upstream_en = 1'b0;
      start_tile(2);
      send_beat(32'h01010101, 32'h02020202);
      send_beat(32'h03030303, 32'h01010101);
      send_beat(32'h7F7F7F7F, 32'h7F7F7F7F);
      send_beat(32'h7F7F7F7F, 32'h7F7F7F7F);
      push_expect();
      collect("extra_beats", 1'b1);
   endtask

   task automatic test_k_zero();
      upstream_en = 1'b0;
      start_tile(0);
      n_checks++;
      if ({accv0, accvs, accvw} !== 3'b111 || acc0 !== 32'd0) $display("FAIL k_zero_hold_next: valids=%b%b%b acc0=%0d required 111 acc0=0", accv0, accvs, accvw, acc0);
      else n_pass++;
      push_expect();
      collect("k_zero", 1'b1);
   endtask

   task automatic test_backpressure_chain();
      upstream_en = 1'b1;
      start_tile(1);
      send_beat(32'h00000005, 32'h00000001);
      push_expect();
      collect("chain_own", 1'b0);
      for (int i = 0; i < 3; i++) begin
         acc_ready = 1'b0;
         @(negedge clk);
         n_checks++;
         if (acc0 !== 32'd5 || accv0 !== 1'b1 || accs !== 20'd5 || inr0 !== 1'b0) $display("FAIL backpressure_hold_%0d: acc0=%0d valid=%b accs=%0d in_ready=%b required 5 1 5 0", i, acc0, accv0, accs, inr0);
         else n_pass++;
      end
      acc_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy0, busys, busyw} !== 3'b111 || accv0 !== 1'b0 || {inr0, inrs, inrw} !== 3'b111) $display("FAIL drain_enter: busy=%b%b%b valid=%b in_ready=%b%b%b required 111 0 111", busy0, busys, busyw, accv0, inr0, inrs, inrw);
      else n_pass++;
      acc_ready    = 1'b0;
      acc_in       = 32'd6;
      acc_in_valid = 1'b1;
      acc_in_last  = 1'b0;
      #1;
      n_checks++;
      if (inr0 !== 1'b0 || accv0 !== 1'b1 || acc0 !== 32'd6) $display("FAIL drain_stall: in_ready=%b valid=%b acc0=%0d required 0 1 6", inr0, accv0, acc0);
      else n_pass++;
      @(negedge clk);
      acc_ready = 1'b1;
      #1;
      n_checks++;
      if (accl0 !== 1'b0 || inr0 !== 1'b1 || accs !== 20'd6) $display("FAIL drain_mid: last=%b in_ready=%b accs=%0d required 0 1 6", accl0, inr0, accs);
      else n_pass++;
      @(negedge clk);
      acc_in      = 32'd7;
      acc_in_last = 1'b1;
      #1;
      n_checks++;
      if (acc0 !== 32'd7 || accl0 !== 1'b1 || accv0 !== 1'b1 || accw !== 20'd7 || acclw !== 1'b1) $display("FAIL drain_last: acc0=%0d last=%b valid=%b accw=%0d required 7 1 1 7", acc0, accl0, accv0, accw);
      else n_pass++;
      @(negedge clk);
      acc_in_valid = 1'b0;
      acc_in_last  = 1'b0;
      acc_ready    = 1'b0;
      n_checks++;
      if ({busy0, busys, busyw} !== 3'b000) $display("FAIL drain_exit_idle: busy=%b%b%b required 000", busy0, busys, busyw);
      else n_pass++;
      upstream_en = 1'b0;
   endtask

   task automatic test_forwarding();
      a_in = 32'h00000005;
      b_in = 32'h0000C300;
      a_v  = 1'b1;
      b_v  = 1'b1;
      @(negedge clk);
      a_in = 32'h77777777;
      b_in = 32'h66666666;
      a_v  = 1'b0;
      b_v  = 1'b0;
      n_checks++;
      if (a_o0 !== 32'h5 || a_os !== 32'h5 || a_ow !== 32'h5 || b_o0 !== 32'hC300 || {av0, avs, avw, bv0} !== 4'b1111) $display("FAIL fwd_valid: a_o0=%h a_os=%h a_ow=%h b_o0=%h required 5 5 5 c300", a_o0, a_os, a_ow, b_o0);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (a_o0 !== 32'h0 || a_os !== 32'h0 || b_o0 !== 32'h0 || {av0, avs, avw, bv0} !== 4'b0000) $display("FAIL fwd_invalid: a_o0=%h a_os=%h b_o0=%h valids=%b required 0", a_o0, a_os, b_o0, {av0, avs, avw, bv0});
      else n_pass++;
      a_in = 32'h0;
      b_in = 32'h0;
      n_checks++;
      if ({busy0, busys, busyw} !== 3'b000) $display("FAIL fwd_idle_discard: busy=%b%b%b required 000", busy0, busys, busyw);
      else n_pass++;
   endtask

   task automatic test_reset_mid_acc();
      upstream_en = 1'b0;
      start_tile(5);
      send_beat(32'h11111111, 32'h22222222);
      send_beat(32'h7F7F7F7F, 32'h7F7F7F7F);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy0, busys, busyw, accv0, accvs, accvw, sat0} !== 7'b0 || acc0 !== 32'd0) $display("FAIL reset_mid_acc: busy=%b%b%b valid=%b acc0=%0d required 0", busy0, busys, busyw, accv0, acc0);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      start_tile(2);
      send_beat(32'h0102FF80, 32'h03040580);
      send_beat(32'hFEFDFCFB, 32'h01020304);
      push_expect();
      collect("after_reset", 1'b1);
   endtask

   task automatic test_random();
      int k;
      upstream_en = 1'b0;
      for (int t = 0; t < 6; t++) begin
         k = $urandom_range(1, 5);
         start_tile(k);
         for (int b = 0; b < k; b++) begin
            idle_cycles($urandom_range(0, 2));
            send_beat($urandom, $urandom);
         end
         push_expect();
         collect($sformatf("random%0d", t), 1'b1);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      a_in         = 32'h0;
      b_in         = 32'h0;
      a_v          = 1'b0;
      b_v          = 1'b0;
      start        = 1'b0;
      k_len        = 16'h0;
      upstream_en  = 1'b0;
      acc_in       = 32'h0;
      acc_in_valid = 1'b0;
      acc_in_last  = 1'b0;
      acc_ready    = 1'b0;
      m_k          = 0;
      m_cnt        = 0;
      m_acc32      = 0; m_acc20s = 0; m_acc20w = 0;
      m_f32        = 1'b0; m_f20s = 1'b0; m_f20w = 1'b0;
      @(negedge clk);

      test_reset();
      test_basic();
      test_saturation();
      test_gaps();
      test_start_ignored();
      test_extra_beats();
      test_k_zero();
      test_backpressure_chain();
      test_forwarding();
      test_reset_mid_acc();
      test_random();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
